square_painter: RTL and testbench
=================================

Name: square_painter

Overview:
- Downstream stage of the 10-square note-lane FSM.
- Consumes one square request per handshake: plot strobe, starting_x, starting_y and colour.
- Expands each request into SIZE x SIZE single-pixel writes for the 160x120 VGA adapter, one pixel per clock.
- Exposes ready so the upstream FSM advances only when the previous square is fully painted.

Parameters:
- SIZE, 4, square edge length in pixels (2..8).
- SCREEN_W, 160, horizontal resolution; pixels with x >= SCREEN_W are suppressed.
- SCREEN_H, 120, vertical resolution; pixels with y >= SCREEN_H are suppressed.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- plot  in  1  request strobe; accepted only when ready=1.
- starting_x  in  8  top-left x of square.
- starting_y  in  7  top-left y of square.
- colour  in  3  RGB colour (3'b000 = erase).
- ready  out  1  high only in IDLE.
- vga_x  out  8  pixel x to adapter.
- vga_y  out  7  pixel y to adapter.
- vga_colour  out  3  pixel colour to adapter.
- vga_write  out  1  adapter write enable.
- done  out  1  one-cycle pulse after the last pixel of a square.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, ready=1, vga_write=0, done=0, vga_x=0, vga_y=0, vga_colour=0, dx=dy=0.
- All outputs are registered.
- States:
  - IDLE: ready=1. On plot=1, latch starting_x, starting_y and colour; clear dx and dy; go to DRAW. Requests with plot=0 are ignored.
  - DRAW: ready=0. Each cycle, drive vga_x=base_x+dx, vga_y=base_y+dy, vga_colour=latched colour.
    - Pixel order is row-major with dx inner.
    - When dx=SIZE-1: dx wraps to 0 and dy increments.
    - When dx=SIZE-1 and dy=SIZE-1: go to DONE.
  - DONE: done=1 for one cycle, vga_write=0, then IDLE.
- Handshake rules:
  - plot is sampled only in IDLE.
  - plot held high continuously starts a new square every SIZE*SIZE+2 cycles.
  - Input changes during DRAW have no effect, because the values are latched.
- Latency: plot sampled at edge N gives the first vga_write=1 after edge N+1 and the last after edge N+SIZE*SIZE. done is high after edge N+SIZE*SIZE+1, and ready is high again after edge N+SIZE*SIZE+2.
- Arithmetic: base+offset is computed at 9 bits (x) and 8 bits (y) before clipping.
- Clipping: if x_sum >= SCREEN_W or y_sum >= SCREEN_H, vga_write=0 for that pixel slot. Counters still advance, so timing does not depend on position.
- No wrap-around on screen: x=158 with SIZE=4 writes only columns 158 and 159.
- Reset mid-DRAW: reset wins over everything; the next cycle is IDLE, vga_write=0, and no done pulse.
- Reset with simultaneous plot: the request is dropped.

Optional Feature:
- Macro: SQUARE_PAINTER_OUTLINE_EN.
- When defined: perimeter pixels (dx=0, dx=SIZE-1, dy=0 or dy=SIZE-1) use 3'b111 (white); interior pixels use the latched colour.
  - Exception: if the latched colour is 3'b000 (erase), all pixels are 3'b000, so erasing stays complete.
- When undefined: every pixel uses the latched colour; no outline logic is synthesised.

Test Plan:
- Reset, then plot=1 for one cycle with x=10, y=112, colour=3'b100 -> exactly 16 writes at (10..13, 112..115) in row-major order, all colour 100; done pulses once, 17 cycles after acceptance; ready returns high.
- plot held high with x=20 and x=30 back to back -> second square starts only after the first done; 32 writes total; no overlap; ready=0 throughout both DRAW phases.
- x=158, y=118, colour=3'b110 -> only 4 writes: (158,118), (159,118), (158,119), (159,119); done still arrives 17 cycles after acceptance.
- reset asserted after the 5th pixel -> vga_write=0 on the next cycle, no done, ready=1; a fresh request afterwards paints all 16 pixels.
- Inputs changed mid-DRAW (x to 50, colour to 001) -> remaining pixels keep the original x=10 and colour=100.
- With SQUARE_PAINTER_OUTLINE_EN, x=40, y=112, colour=3'b010 -> 12 perimeter pixels are 111 and the 4 interior pixels (41..42, 113..114) are 010; with colour=000, all 16 pixels are 000.

Source files
------------

// File: rtl/square_painter_if.sv
// rtl/square_painter_if.sv - request and pixel-write bundle between the note-lane FSM, the painter and the VGA adapter
//
// Signals:
//   plot        request strobe from the upstream FSM
//   starting_x  top-left x of the square (8 bits)
//   starting_y  top-left y of the square (7 bits)
//   colour      RGB colour, 3'b000 erases
//   ready       painter is idle and will sample plot
//   vga_x       pixel x to the adapter
//   vga_y       pixel y to the adapter
//   vga_colour  pixel colour to the adapter
//   vga_write   adapter write enable
//   done        one-cycle pulse after the last pixel of a square
// Modports: master = upstream/adapter side, slave = painter.
interface square_painter_if;
  logic       plot;
  logic [7:0] starting_x;
  logic [6:0] starting_y;
  logic [2:0] colour;
  logic       ready;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_write;
  logic       done;

  modport master (
    output plot, starting_x, starting_y, colour,
    input  ready, vga_x, vga_y, vga_colour, vga_write, done
  );

  modport slave (
    input  plot, starting_x, starting_y, colour,
    output ready, vga_x, vga_y, vga_colour, vga_write, done
  );
endinterface

// File: rtl/square_painter.sv
// rtl/square_painter.sv - expands one square request into SIZE x SIZE clipped VGA pixel writes
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    square_painter_if.slave (request in, pixel writes / ready / done out)
// Parameters: SIZE (2..8), SCREEN_W, SCREEN_H.
// Optional: define SQUARE_PAINTER_OUTLINE_EN to paint the perimeter white
// (erase requests stay fully black).
module square_painter #(
  parameter int SIZE     = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic             clk,
  input  logic             reset,
  square_painter_if.slave  bus
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
  localparam logic [8:0]    XLIM = 9'(SCREEN_W);
  localparam logic [7:0]    YLIM = 8'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    base_x_q, base_x_d;
  logic [6:0]    base_y_q, base_y_d;
  logic [2:0]    colour_q, colour_d;
  logic [CW-1:0] dx_q, dx_d;
  logic [CW-1:0] dy_q, dy_d;
  logic          ready_q, ready_d;
  logic [7:0]    vga_x_q, vga_x_d;
  logic [6:0]    vga_y_q, vga_y_d;
  logic [2:0]    vga_colour_q, vga_colour_d;
  logic          vga_write_q, vga_write_d;
  logic          done_q, done_d;

  // Sums are one bit wider than the screen coordinates so squares that
  // overhang the right/bottom edge are clipped instead of wrapping.
  logic [8:0] x_sum;
  logic [7:0] y_sum;
  logic [2:0] pixel_colour;

  assign x_sum = {1'b0, base_x_q} + 9'(dx_q);
  assign y_sum = {1'b0, base_y_q} + 8'(dy_q);

`ifdef SQUARE_PAINTER_OUTLINE_EN
  logic on_edge;
  assign on_edge = (dx_q == '0) || (dx_q == LAST) || (dy_q == '0) || (dy_q == LAST);
  // Erase requests must clear the whole square, outline included.
  assign pixel_colour = (on_edge && (colour_q != 3'b000)) ? 3'b111 : colour_q;
`else
  assign pixel_colour = colour_q;
`endif

  always_comb begin
    state_d      = state_q;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    colour_d     = colour_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    ready_d      = 1'b0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_write_d  = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.plot) begin
          base_x_d = bus.starting_x;
          base_y_d = bus.starting_y;
          colour_d = bus.colour;
          dx_d     = '0;
          dy_d     = '0;
          ready_d  = 1'b0;
          state_d  = S_DRAW;
        end
      end
      S_DRAW: begin
        vga_x_d      = x_sum[7:0];
        vga_y_d      = y_sum[6:0];
        vga_colour_d = pixel_colour;
        // Off-screen slots still consume a cycle so timing is position-independent.
        vga_write_d  = (x_sum < XLIM) && (y_sum < YLIM);
        if (dx_q == LAST) begin
          dx_d = '0;
          if (dy_q == LAST) begin
            state_d = S_DONE;
          end else begin
            dy_d = dy_q + CW'(1);
          end
        end else begin
          dx_d = dx_q + CW'(1);
        end
      end
      S_DONE: begin
        // ready stays low during the done pulse; it rises one cycle later.
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      base_x_q     <= '0;
      base_y_q     <= '0;
      colour_q     <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      ready_q      <= 1'b1;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_write_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      colour_q     <= colour_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      ready_q      <= ready_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_write_q  <= vga_write_d;
      done_q       <= done_d;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_write  = vga_write_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_square_painter.sv
// tb/tb_square_painter.sv - directed scoreboard bench for square_painter
module tb_square_painter;

  localparam int SIZE = 4;

  logic clk = 1'b0;
  logic reset;

  square_painter_if bus ();

  square_painter #(.SIZE(SIZE), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int writes = 0;
  int ready_hi = 0;
  int done_cnt = 0;
  logic [17:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_col(input int dx, input int dy, input logic [2:0] c);
`ifdef SQUARE_PAINTER_OUTLINE_EN
    if (c != 3'b000 && (dx == 0 || dx == SIZE-1 || dy == 0 || dy == SIZE-1))
      return 3'b111;
`endif
    return c;
  endfunction

  task automatic push_square(input int x, input int y, input logic [2:0] c);
    for (int dy = 0; dy < SIZE; dy++)
      for (int dx = 0; dx < SIZE; dx++)
        if (x + dx < 160 && y + dy < 120)
          exp_q.push_back({8'(x + dx), 7'(y + dy), exp_col(dx, dy, c)});
  endtask

  // One clock edge, then sample outputs 1 ns later and score any pixel write.
  task automatic cycle();
    logic [17:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.ready === 1'b1) ready_hi++;
    if (bus.done === 1'b1) done_cnt++;
    if (bus.vga_write === 1'b1) begin
      writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'h3ffff);
      end else begin
        e = exp_q.pop_front();
        check("pixel", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'(e));
      end
    end
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (bus.done === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Drive a one-cycle request; returns the cycle index of the accepting edge.
  task automatic request(input int x, input int y, input logic [2:0] c, output int acc);
    bus.plot = 1'b1;
    bus.starting_x = 8'(x);
    bus.starting_y = 7'(y);
    bus.colour = c;
    push_square(x, y, c);
    cycle();
    acc = cyc;
    bus.plot = 1'b0;
    writes = 0;
    ready_hi = 0;
    done_cnt = 0;
  endtask

  task automatic square_test(input string tag, input int x, input int y, input logic [2:0] c,
                             input int nwrites);
    int acc, at;
    request(x, y, c, acc);
    wait_done(40, at);
    check({tag, "_done_latency"}, 32'(at - acc), 32'(SIZE*SIZE + 1));
    check({tag, "_writes"}, 32'(writes), 32'(nwrites));
    check({tag, "_ready_busy"}, 32'(ready_hi), 32'd0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    cycle();
    check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int acc, acc2, at;

    bus.plot = 1'b0;
    bus.starting_x = '0;
    bus.starting_y = '0;
    bus.colour = '0;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_write", 32'(bus.vga_write), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_vga_x", 32'(bus.vga_x), 32'd0);
    check("rst_vga_y", 32'(bus.vga_y), 32'd0);
    check("rst_colour", 32'(bus.vga_colour), 32'd0);

    // plot low with busy inputs: nothing happens
    bus.starting_x = 8'd77;
    bus.colour = 3'b101;
    writes = 0;
    for (int i = 0; i < 5; i++) cycle();
    check("idle_no_write", 32'(writes), 32'd0);

    // basic square
    square_test("basic", 10, 112, 3'b100, 16);

    // plot held high: two squares back to back, 18 cycles apart
    bus.plot = 1'b1;
    bus.starting_x = 8'd20;
    bus.starting_y = 7'd0;
    bus.colour = 3'b011;
    push_square(20, 0, 3'b011);
    push_square(30, 0, 3'b011);
    cycle();
    acc = cyc;
    writes = 0;
    ready_hi = 0;
    bus.starting_x = 8'd30;
    wait_done(40, at);
    check("b2b_first_done", 32'(at - acc), 32'(SIZE*SIZE + 1));
    cycle();
    acc2 = cyc;
    bus.plot = 1'b0;
    check("b2b_period", 32'(acc2 - acc), 32'(SIZE*SIZE + 2));
    wait_done(40, at);
    check("b2b_second_done", 32'(at - acc2), 32'(SIZE*SIZE + 1));
    check("b2b_writes", 32'(writes), 32'd32);
    check("b2b_ready_busy", 32'(ready_hi), 32'd0);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    cycle();

    // clipping at the bottom-right corner
    square_test("clip", 158, 118, 3'b110, 4);

    // reset after the fifth pixel aborts the square
    request(10, 112, 3'b100, acc);
    for (int i = 0; i < 10 && writes < 5; i++) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("abort_write", 32'(bus.vga_write), 32'd0);
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_pending", 32'(exp_q.size()), 32'd11);
    exp_q.delete();
    done_cnt = 0;
    writes = 0;
    for (int i = 0; i < 20; i++) cycle();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_no_write", 32'(writes), 32'd0);
    square_test("after_abort", 10, 112, 3'b100, 16);

    // reset together with plot drops the request
    bus.plot = 1'b1;
    reset = 1'b1;
    cycle();
    bus.plot = 1'b0;
    reset = 1'b0;
    writes = 0;
    for (int i = 0; i < 20; i++) cycle();
    check("rst_plot_dropped", 32'(writes), 32'd0);

    // inputs changed mid-draw are ignored
    request(10, 112, 3'b100, acc);
    cycle();
    cycle();
    cycle();
    bus.starting_x = 8'd50;
    bus.starting_y = 7'd3;
    bus.colour = 3'b001;
    wait_done(40, at);
    check("latched_done", 32'(at - acc), 32'(SIZE*SIZE + 1));
    check("latched_writes", 32'(writes), 32'd16);
    check("latched_queue", 32'(exp_q.size()), 32'd0);
    cycle();

    // outline colour (and full erase) at x=40, y=112
    square_test("colour", 40, 112, 3'b010, 16);
    square_test("erase", 40, 112, 3'b000, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
